sdm_decim: RTL and testbench
============================

# sdm_decim

Sigma-delta demodulator: recovers W_OUT-bit sample values from a 1-bit sigma-delta stream, such as the DAC output of the sine generator. A second-order CIC (sinc²) decimator filters by R = 2^LOG2_DEC and emits one scaled, saturated sample per R enabled clocks with a one-cycle valid strobe. Used in loopback self-test and as the capture front end for measuring generated waveforms.

## Interface
- LOG2_DEC, 5, log2 of decimation ratio R (R = 32); must satisfy 2·LOG2_DEC ≥ W_OUT
- W_OUT, 8, output sample width (unsigned, matches sine ROM width)
- clk  in  1  system clock, all logic on rising edge
- clr  in  1  reset, asynchronous, active-high
- en  in  1  sample enable; din consumed only when high
- din  in  1  sigma-delta bitstream, 1 = full-scale pulse
- dout  out  W_OUT  last decimated sample, unsigned
- dout_valid  out  1  one-cycle strobe, dout new this cycle
- sat  out  1  high with dout_valid when the sample was clipped

## Operation
- W_ACC = 2·LOG2_DEC+1. All integrator/comb arithmetic unsigned mod 2^W_ACC; wraparound is intentional and must not be saturated.
- Integrators, per enabled cycle: i1 ← i1 + din; i2 ← i2 + i1 (both registered, old values on RHS).
- Decimation counter cnt (LOG2_DEC bits) increments per enabled cycle; tick = en & (cnt == R−1); cnt wraps to 0.
- On tick edge: c1 ← i2 − i2_d; i2_d ← i2; c2 ← c1_new − c1_d; c1_d ← c1_new. c2 holds sum in 0..R².
- Scaling: s = c2 >> (2·LOG2_DEC − W_OUT); if s ≥ 2^W_OUT then dout = all-ones, sat = 1, else dout = s, sat = 0.
- Warm-up: outputs from the first 2 ticks after reset are discarded (dout_valid stays 0, dout unchanged); 2-bit warm-up counter saturates at 2.
- en low: integrators, cnt, combs and warm-up all hold; a pending output strobe still completes.
- Steady state: constant density d (ones per cycle) yields dout ≈ d·2^W_OUT, clipped at 2^W_OUT−1.

## Timing
- Reset (async, immediate): i1, i2, i2_d, c1_d, c2, cnt, warm-up = 0; dout = 0; dout_valid = 0; sat = 0.
- Tick in cycle k → comb result registered at end of k → dout, sat, dout_valid registered at end of k+1; dout_valid high exactly in cycle k+2, low otherwise.
- dout and sat hold between strobes.
- First valid strobe after reset with en constantly high: tick 3 at cycle 3R−1 (cycle 0 = first cycle after clr falls), strobe in cycle 3R+1.
- clr asserted mid-period or mid-strobe: all state clears at once, pending strobe dropped, warm-up restarts.
- en deasserted on a would-be tick cycle: no tick; cnt stays R−1 until next enabled cycle.
- Throughput: one sample per R enabled cycles; no back-pressure, consumer must take dout on dout_valid.

## Structure
- Shared package: W_ACC derivation, scaling shift constant, warm-up count (2).
- One natural sub-module: sdm_cic_integ (two cascaded enabled integrators, W_ACC wide), instantiated once; counter, combs, scaling and warm-up stay in the top.
- No memories; pure registers.

## Test plan
- din constant 0, en=1, defaults → every strobe from the 3rd tick on: dout=0, sat=0; strobes spaced 32 cycles.
- din constant 1 → steady dout=255 (255), sat=1 on each strobe (c2=1024, >>2 = 256 clipped).
- din alternating 1,0 → steady dout=128, sat=0; din 1 of every 4 → dout=64.
- Loopback from sine generator with phase increment 1 → dout sequence tracks the sine ROM within ±2 LSB after the filter delay, no sat.
- en toggled 1-of-2 cycles with din=1010 per enabled cycle → dout=128, strobe spacing 64 clocks; integrator values unchanged across en-low cycles.
- clr pulsed 10 cycles before an expected strobe → no strobe, dout=0 immediately, next valid strobe 3R+1 cycles after clr falls.

Source files
------------

// File: rtl/sdm_decim_pkg.sv
// -----------------------------------------------------------------------------
// sdm_decim_pkg
//   Constants and helpers shared by the sigma-delta demodulator (sdm_decim)
//   and its integrator stage (sdm_cic_integ).
//   - acc_width   : CIC accumulator width for a given decimation exponent
//   - scale_shift : right shift that maps the CIC gain R^2 onto W_OUT bits
//   - WARMUP_TICKS: decimation ticks discarded after reset while the comb
//                   delay registers fill with real history
// -----------------------------------------------------------------------------
package sdm_decim_pkg;

    localparam int WARMUP_TICKS = 2;

    // Second-order CIC gain is R^2 = 2^(2*log2_dec). One extra bit holds the
    // value R^2 itself, which a full-scale input produces.
    function automatic int acc_width(input int log2_dec);
        return 2 * log2_dec + 1;
    endfunction

    function automatic int scale_shift(input int log2_dec, input int w_out);
        return 2 * log2_dec - w_out;
    endfunction

endpackage

// File: rtl/sdm_cic_integ.sv
// -----------------------------------------------------------------------------
// sdm_cic_integ
//   Two cascaded integrators of a second-order CIC decimator, running at the
//   input sample rate. Arithmetic wraps mod 2^W_ACC; the comb stage relies on
//   that wraparound, so nothing here saturates.
// Ports
//   clk    system clock
//   clr    asynchronous active-high clear
//   en_i   sample enable; integrators hold while low
//   din_i  1-bit sigma-delta input
//   i2_o   second integrator state
// -----------------------------------------------------------------------------
module sdm_cic_integ #(
    parameter int W_ACC = 11
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en_i,
    input  logic             din_i,
    output logic [W_ACC-1:0] i2_o
);

    logic [W_ACC-1:0] i1_q, i1_d;
    logic [W_ACC-1:0] i2_q, i2_d;

    // Both updates use the old register values on the right-hand side.
    always_comb begin
        i1_d = i1_q;
        i2_d = i2_q;
        if (en_i) begin
            i1_d = i1_q + W_ACC'(din_i);
            i2_d = i2_q + i1_q;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            i1_q <= '0;
            i2_q <= '0;
        end else begin
            i1_q <= i1_d;
            i2_q <= i2_d;
        end
    end

    assign i2_o = i2_q;

endmodule

// File: rtl/sdm_decim.sv
// -----------------------------------------------------------------------------
// sdm_decim
//   Sigma-delta demodulator: sinc^2 (second-order CIC) decimation of a 1-bit
//   stream by R = 2^LOG2_DEC, scaled and clipped to an unsigned W_OUT-bit
//   sample, one per R enabled clocks, flagged by a one-cycle strobe.
// Ports
//   clk         system clock
//   clr         asynchronous active-high clear
//   en          sample enable; din consumed only when high
//   din         sigma-delta bitstream
//   dout        last decimated sample (held between strobes)
//   dout_valid  one-cycle strobe, dout new this cycle
//   sat         sample was clipped to all-ones (valid with dout_valid)
// Latency: tick in cycle k -> comb result at end of k -> outputs at end of
// k+1, so dout_valid is high in cycle k+2.
// -----------------------------------------------------------------------------
module sdm_decim
    import sdm_decim_pkg::*;
#(
    parameter int LOG2_DEC = 5,
    parameter int W_OUT    = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [W_OUT-1:0] dout,
    output logic             dout_valid,
    output logic             sat
);

    localparam int W_ACC = acc_width(LOG2_DEC);
    localparam int SHIFT = scale_shift(LOG2_DEC, W_OUT);

    logic [W_ACC-1:0]    i2;
    logic [LOG2_DEC-1:0] cnt_q, cnt_d;
    logic [W_ACC-1:0]    i2_dly_q, i2_dly_d;
    logic [W_ACC-1:0]    c1_dly_q, c1_dly_d;
    logic [W_ACC-1:0]    c2_q, c2_d;
    logic [1:0]          warm_q, warm_d;
    logic [1:0]          vld_q, vld_d;       // [0]: comb result ready, [1]: strobe
    logic [W_OUT-1:0]    dout_q, dout_d;
    logic                sat_q, sat_d;

    logic                tick;
    logic                warm_done;
    logic [W_ACC-1:0]    c1_new, c2_new;
    logic [W_ACC-1:0]    c2_sh;
    logic                clip;

    sdm_cic_integ #(.W_ACC(W_ACC)) u_integ (
        .clk   (clk),
        .clr   (clr),
        .en_i  (en),
        .din_i (din),
        .i2_o  (i2)
    );

    // Last count of the period is all-ones, so the compare is a reduction AND.
    assign tick      = en & (&cnt_q);
    assign warm_done = (warm_q == 2'(WARMUP_TICKS));

    // Comb differences wrap mod 2^W_ACC by design.
    assign c1_new = i2 - i2_dly_q;
    assign c2_new = c1_new - c1_dly_q;

    // Anything left above W_OUT after the shift means the sample overflowed.
    assign c2_sh = c2_q >> SHIFT;
    assign clip  = |c2_sh[W_ACC-1:W_OUT];

    always_comb begin
        cnt_d    = cnt_q;
        i2_dly_d = i2_dly_q;
        c1_dly_d = c1_dly_q;
        c2_d     = c2_q;
        warm_d   = warm_q;
        vld_d    = {vld_q[0], tick & warm_done};
        dout_d   = dout_q;
        sat_d    = sat_q;

        if (en) begin
            cnt_d = cnt_q + LOG2_DEC'(1);
        end

        if (tick) begin
            i2_dly_d = i2;
            c1_dly_d = c1_new;
            c2_d     = c2_new;
            if (!warm_done) begin
                warm_d = warm_q + 2'd1;
            end
        end

        // Output stage runs off the pipeline bit, not en, so a strobe that is
        // already in flight completes even if en drops.
        if (vld_q[0]) begin
            sat_d  = clip;
            dout_d = clip ? '1 : c2_sh[W_OUT-1:0];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q    <= '0;
            i2_dly_q <= '0;
            c1_dly_q <= '0;
            c2_q     <= '0;
            warm_q   <= '0;
            vld_q    <= '0;
            dout_q   <= '0;
            sat_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            i2_dly_q <= i2_dly_d;
            c1_dly_q <= c1_dly_d;
            c2_q     <= c2_d;
            warm_q   <= warm_d;
            vld_q    <= vld_d;
            dout_q   <= dout_d;
            sat_q    <= sat_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = vld_q[1];
    assign sat        = sat_q;

endmodule

// File: tb/tb_sdm_decim.sv
// -----------------------------------------------------------------------------
// tb_sdm_decim
//   Table of constant-density patterns (with optional enable thinning and
//   enable gaps) plus hand sequences for clear before and during a pending
//   strobe. The driver pushes the expected sample, sat flag and arrival
//   cycle whenever it drives a tick cycle; a negedge monitor pops and
//   compares each strobe, flags strobes nobody expected and strobes that
//   never arrived, and checks dout/sat hold between strobes.
// -----------------------------------------------------------------------------
module tb_sdm_decim;

    localparam int R = 32;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       en  = 1'b0;
    logic       din = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       sat;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sdm_decim #(.LOG2_DEC(5), .W_OUT(8)) dut (
        .clk        (clk),
        .clr        (clr),
        .en         (en),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sat        (sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic [3:0] pat;      // din for enabled sample e is pat[e % 4]
        int         en_div;   // en high on every en_div-th clock
        int         gap_e;    // hold en low before enabled sample gap_e ...
        int         gap_len;  // ... for this many clocks
        int         n_en;     // enabled samples to drive
        logic [7:0] exp_dout;
        logic       exp_sat;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] dout;
        logic       sat;
        int         due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] hold_dout = 8'd0;
    logic       hold_sat  = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Strobe scoreboard and hold checks, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t x;
        if (clr) begin
            hold_dout = 8'd0;
            hold_sat  = 1'b0;
        end else if (dout_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                x = sb.pop_front();
                chk({x.name, "_dout"}, int'(dout), int'(x.dout));
                chk({x.name, "_sat"},  int'(sat),  int'(x.sat));
                chk({x.name, "_cycle"}, cyc, x.due);
                hold_dout = x.dout;
                hold_sat  = x.sat;
            end
        end else begin
            chk("hold_dout", int'(dout), int'(hold_dout));
            chk("hold_sat",  int'(sat),  int'(hold_sat));
        end
        while (sb.size() > 0 && sb[0].due < cyc) begin
            x = sb.pop_front();
            chk({x.name, "_missing_strobe"}, 0, 1);
        end
    end

    // Clear asserted right after a posedge; outputs must drop immediately.
    task automatic do_reset();
        en  = 1'b0;
        din = 1'b0;
        clr = 1'b1;
        sb.delete();
        #1;
        chk("reset_dout",  int'(dout),       0);
        chk("reset_valid", int'(dout_valid), 0);
        chk("reset_sat",   int'(sat),        0);
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;                 // this cycle is cycle 0
    endtask

    task automatic drive(input vec_t v);
        int   e   = 0;
        int   c   = 0;
        int   gap = v.gap_len;
        logic en_b;
        while (e < v.n_en) begin
            if (e == v.gap_e && gap > 0) begin
                en_b = 1'b0;
                gap--;
            end else begin
                en_b = (c % v.en_div) == 0;
            end
            en  = en_b;
            din = en_b ? v.pat[e % 4] : 1'($urandom);
            if (en_b) begin
                // Ticks 1 and 2 are warm-up; from tick 3 on a strobe lands
                // two cycles after the tick cycle.
                if (e % R == R - 1 && e >= 3 * R - 1)
                    sb.push_back('{v.name, v.exp_dout, v.exp_sat, cyc + 2});
                e++;
            end
            c++;
            @(posedge clk);
            #1;
        end
        en  = 1'b0;
        din = 1'b0;
    endtask

    task automatic flush(input string nm);
        repeat (4) @(posedge clk);
        #1;
        chk({nm, "_sb_empty"}, sb.size(), 0);
    endtask

    vec_t vecs[8];

    initial begin
        vec_t v;
        // c2 steady value = R * (ones per R samples); dout = c2 >> 2, clip at 255.
        vecs[0] = '{"zero",     4'b0000, 1, -1, 0, 192, 8'd0,   1'b0};
        vecs[1] = '{"ones",     4'b1111, 1, -1, 0, 192, 8'd255, 1'b1};
        vecs[2] = '{"half",     4'b0101, 1, -1, 0, 192, 8'd128, 1'b0};
        vecs[3] = '{"quarter",  4'b0001, 1, -1, 0, 192, 8'd64,  1'b0};
        vecs[4] = '{"three_q",  4'b0111, 1, -1, 0, 192, 8'd192, 1'b0};
        vecs[5] = '{"en_half",  4'b0101, 2, -1, 0, 192, 8'd128, 1'b0};
        vecs[6] = '{"gap_tick", 4'b1111, 1, 95, 5, 192, 8'd255, 1'b1};
        vecs[7] = '{"gap_mid",  4'b0001, 1, 110, 7, 192, 8'd64, 1'b0};

        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            do_reset();
            drive(vecs[i]);
            flush(vecs[i].name);
        end

        // Clear 10 cycles before the 4th-tick strobe: the strobe is lost and
        // the sequence restarts from a full warm-up.
        v = vecs[1];
        v.name = "clr_pre";
        do_reset();
        v.n_en = 4 * R - 1 - 10 + 2;   // stop at the start of cycle 119
        drive(v);
        chk("clr_pre_dout_before", int'(dout), 255);
        do_reset();
        v.n_en = 4 * R;
        drive(v);
        flush("clr_pre");

        // Clear in the cycle between tick 3 and its strobe: strobe dropped.
        v = vecs[2];
        v.name = "clr_mid";
        do_reset();
        v.n_en = 3 * R;                // tick 3 driven, now in cycle 96
        drive(v);
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        chk("clr_mid_no_strobe_dout", int'(dout), 0);
        v.n_en = 4 * R;
        drive(v);
        flush("clr_mid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
